// File: rtl/aes128_key_sched_seq.sv
// aes128_key_sched_seq
// Sequential AES-128 key schedule. The cipher key is loaded on start and then
// round keys 0..NUM_ROUNDS are emitted one per valid/ready handshake. Each
// next key is built combinationally from the registered current key, using
// SubWord(RotWord(w3)) and the running Rcon byte.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   start, key_in      load request (sampled only when idle) and cipher key
//   abort              synchronous flush back to idle
//   rk_valid/rk_ready  round-key stream handshake
//   round_key, rk_idx  current round key (w0 in [127:96]) and its round number
//   busy, done         not idle / one-cycle pulse after the last key is taken
// Optional macro AES128_KEY_SCHED_CACHE_EN adds an 11-entry round-key cache:
//   cache_idx (in), cache_key (registered read, 1-cycle latency), cache_full.
module aes128_key_sched_seq #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter logic [7:0]  RCON_INIT  = 8'h01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         abort,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
`ifdef AES128_KEY_SCHED_CACHE_EN
  ,
  input  logic [3:0]   cache_idx,
  output logic [127:0] cache_key,
  output logic         cache_full
`endif
);

  localparam logic [3:0] LAST_IDX = NUM_ROUNDS[3:0];

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} stateE;

  function automatic logic [7:0] subByte(input logic [7:0] b);
    return SBOX[(11'd2040 - {b, 3'b000}) +: 8];
  endfunction

  // SubWord(RotWord(w)): rotate bytes left by one, then substitute each.
  function automatic logic [31:0] rotWordSubBytes(input logic [31:0] w);
    return {subByte(w[23:16]), subByte(w[15:8]), subByte(w[7:0]), subByte(w[31:24])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  stateE        stateR, stateNxtS;
  logic [7:0]   rconR;
  logic         loadKeyS, advanceS, finishS;
  logic [31:0]  tempS, n0S, n1S, n2S, n3S;
  logic [127:0] nextKeyS;

  assign rk_valid = (stateR == EMIT);
  assign busy     = (stateR == EMIT);

  // Next round key from the registered current key and Rcon.
  always_comb begin
    tempS    = rotWordSubBytes(round_key[31:0]) ^ {rconR, 24'h000000};
    n0S      = round_key[127:96] ^ tempS;
    n1S      = round_key[95:64]  ^ n0S;
    n2S      = round_key[63:32]  ^ n1S;
    n3S      = round_key[31:0]   ^ n2S;
    nextKeyS = {n0S, n1S, n2S, n3S};
  end

  // FSM next-state decode; abort outranks both start and a handshake.
  always_comb begin
    stateNxtS = stateR;
    loadKeyS  = 1'b0;
    advanceS  = 1'b0;
    finishS   = 1'b0;
    case (stateR)
      IDLE: begin
        if (abort) begin
          stateNxtS = IDLE;
        end else if (start) begin
          stateNxtS = EMIT;
          loadKeyS  = 1'b1;
        end else begin
          stateNxtS = IDLE;
        end
      end
      EMIT: begin
        if (abort) begin
          stateNxtS = IDLE;
        end else if (rk_ready) begin
          if (rk_idx == LAST_IDX) begin
            stateNxtS = IDLE;
            finishS   = 1'b1;
          end else begin
            advanceS  = 1'b1;
          end
        end else begin
          stateNxtS = EMIT;
        end
      end
      default: begin
        stateNxtS = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNxtS;
    end
  end

  // Round-key, index and Rcon registers plus the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_key <= 128'h0;
      rk_idx    <= 4'd0;
      rconR     <= RCON_INIT;
      done      <= 1'b0;
    end else begin
      done <= finishS;
      if (loadKeyS) begin
        round_key <= key_in;
        rk_idx    <= 4'd0;
        rconR     <= RCON_INIT;
      end else if (advanceS) begin
        round_key <= nextKeyS;
        rk_idx    <= rk_idx + 4'd1;
        rconR     <= xtime(rconR);
      end
    end
  end

`ifdef AES128_KEY_SCHED_CACHE_EN
  logic [127:0] cacheMem [0:10];

  // Cache write at the edge that makes a key valid, full flag and registered read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) begin
        cacheMem[i] <= 128'h0;
      end
      cache_full <= 1'b0;
      cache_key  <= 128'h0;
    end else begin
      if (loadKeyS) begin
        cacheMem[0] <= key_in;
      end else if (advanceS) begin
        cacheMem[rk_idx + 4'd1] <= nextKeyS;
      end
      if (loadKeyS || abort) begin
        cache_full <= 1'b0;
      end else if (finishS) begin
        cache_full <= 1'b1;
      end
      if (cache_full && (cache_idx <= 4'd10)) begin
        cache_key <= cacheMem[cache_idx];
      end else begin
        cache_key <= 128'h0;
      end
    end
  end
`endif

endmodule
